pe_output_writer: RTL and testbench
===================================

Name: pe_output_writer

Overview:
- Sits directly downstream of the PE.
- Consumes the free-running PE output stream (one result per clock while valid) and discards the border columns that the convolver produces at row wrap.
- Saturates each kept result from WID_PE_BITS+1 bits to WID_PE_BITS bits and buffers it in a small FIFO.
- Issues addressed writes to the output feature-map buffer over a valid/ready port.

Parameters:
- WID_PE_BITS, 16, data width of a stored output word; PE output is WID_PE_BITS+1 bits, signed
- KER, 3, convolution kernel size; each row drops KER-1 columns
- ADDR_W, 16, output buffer address width
- FIFO_DEPTH, 8, number of FIFO entries (power of 2)
- DIM_W, 10, width of the row_length and out_rows registers

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; latches config and begins a frame
- row_length  in  DIM_W  input image width (samples per PE row); must be >= KER
- out_rows  in  DIM_W  number of PE rows to consume; must be >= 1
- base_addr  in  ADDR_W  first write address
- in_valid  in  1  PE output valid; no backpressure to the PE
- in_data  in  WID_PE_BITS+1  signed PE result
- wr_valid  out  1  write request
- wr_ready  in  1  buffer accepts write
- wr_addr  out  ADDR_W  write address
- wr_data  out  WID_PE_BITS  saturated result
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the frame is fully written
- overflow  out  1  sticky; a kept sample was dropped because the FIFO was full

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, FIFO empty, all counters 0.
- States:
  - IDLE: start loads row_length, out_rows and base_addr into registers, clears col, row, out_idx and overflow, then goes to RUN.
  - RUN: every in_valid cycle increments col. When col == row_length-1, col wraps to 0 and row increments. When the sample with row == out_rows-1 and col == row_length-1 is consumed, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, then go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- busy = (state != IDLE).
- start outside IDLE is ignored.
- in_valid outside RUN is ignored.
- Keep rule: a sample is kept iff col <= row_length-KER, giving row_length-KER+1 kept samples per row. Other samples are discarded without using an address.
- Address generation:
  - Each kept sample is assigned wr_addr = base_addr + out_idx, modulo 2^ADDR_W (wraps silently).
  - out_idx increments on every kept sample, including dropped ones, so later addresses are unaffected by a drop.
- Saturation:
  - in_data >  2^(W-1)-1 → 2^(W-1)-1
  - in_data < -2^(W-1) → -2^(W-1)
  - otherwise truncate to W bits (W = WID_PE_BITS)
- FIFO:
  - Each entry holds {addr, data}.
  - Push occurs when a kept sample arrives and count < FIFO_DEPTH, evaluated on the count before any same-cycle pop. A push when full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Pop occurs when wr_valid && wr_ready.
- Write port:
  - wr_valid = FIFO non-empty; wr_addr and wr_data show the head entry.
  - Latency: a kept sample pushed in cycle n can appear on wr_valid in cycle n+1 at the earliest.
  - wr_valid, wr_addr and wr_data stay stable while wr_ready is low.
- overflow holds until the next accepted start or rst.
- rst asserted mid-frame: immediate return to IDLE, FIFO flushed, no done pulse.

Test Plan:
- Basic frame: row_length=6, out_rows=2, base_addr=0x100, in_data=0..11 with continuous in_valid, wr_ready=1 → 8 writes:
  - (0x100,0) (0x101,1) (0x102,2) (0x103,3) (0x104,6) (0x105,7) (0x106,8) (0x107,9)
  - done pulses once after the last write; overflow=0.
- Saturation, W=16: in_data=17'h09000 → 16'h7FFF; 17'h10000 (-65536) → 16'h8000; 17'h1FFFF (-1) → 16'hFFFF; 17'h00123 → 16'h0123.
- Backpressure/overflow: row_length=12, out_rows=1, wr_ready=0 throughout RUN → 10 kept samples, first 8 stored, samples 8 and 9 dropped, overflow=1. Raising wr_ready then gives 8 writes at addresses base..base+7, followed by done.
- Gapped input: in_valid toggling 1/0 for the basic frame → identical 8 writes with identical addresses; no sample lost.
- Start while busy: second start mid-RUN with base_addr=0x200 → ignored; all addresses remain based at 0x100.
- Reset mid-frame: rst asserted after 5 samples → wr_valid=0 and busy=0 immediately, no done. A new start then runs the basic frame correctly.

Source files
------------

// File: rtl/pe_output_writer.sv
// pe_output_writer: drops convolver border columns, saturates PE results and
// queues addressed writes to the output feature-map buffer through a small FIFO.
module pe_output_writer #(
  parameter int WID_PE_BITS = 16,
  parameter int KER         = 3,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIM_W       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       row_length,
  input  logic [DIM_W-1:0]       out_rows,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   in_valid,
  input  logic [WID_PE_BITS:0]   in_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [WID_PE_BITS-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  localparam int W  = WID_PE_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            state_q;
  logic [DIM_W-1:0]  rl_q, rows_q, col_q, row_q, col_d, row_d;
  logic [ADDR_W-1:0] base_q, idx_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];
  logic [W-1:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              keep, full, push, pop, col_end, last;
  logic [W-1:0]      sat;
  assign keep    = state_q == RUN && in_valid && col_q <= rl_q - DIM_W'(KER);
  assign full    = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign push    = keep && !full;
  assign pop     = wr_valid && wr_ready;
  assign col_end = col_q == rl_q - DIM_W'(1);
  assign last    = col_end && row_q == rows_q - DIM_W'(1);
  // Top two bits differing means the value does not fit in W signed bits.
  assign sat     = (in_data[W] != in_data[W-1]) ? {in_data[W], {(W-1){~in_data[W]}}} : in_data[W-1:0];
  assign cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign col_d   = col_end ? '0 : col_q + DIM_W'(1);
  assign row_d   = col_end ? row_q + DIM_W'(1) : row_q;
  assign wr_valid = cnt_q != '0;
  assign wr_addr  = wr_valid ? mem_a[rp_q] : '0;
  assign wr_data  = wr_valid ? mem_d[rp_q] : '0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign overflow = ovf_q;
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wp_q] <= base_q + idx_q;
      mem_d[wp_q] <= sat;
    end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rl_q    <= '0;
      rows_q  <= '0;
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      wp_q  <= push ? wp_q + AW'(1) : wp_q;
      rp_q  <= pop ? rp_q + AW'(1) : rp_q;
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (start) begin
          rl_q    <= row_length;
          rows_q  <= out_rows;
          base_q  <= base_addr;
          col_q   <= '0;
          row_q   <= '0;
          idx_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (in_valid) begin
          col_q   <= col_d;
          row_q   <= row_d;
          idx_q   <= keep ? idx_q + ADDR_W'(1) : idx_q;
          ovf_q   <= ovf_q | (keep && full);
          state_q <= last ? DRAIN : RUN;
        end
        DRAIN: state_q <= (cnt_q == '0) ? DONE : DRAIN;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_output_writer.sv
// tb_pe_output_writer: directed frames with hand-computed write streams.
module tb_pe_output_writer;
  logic        clk = 0, rst, start, in_valid, wr_ready, wr_valid, busy, done, overflow;
  logic [9:0]  row_length, out_rows;
  logic [15:0] base_addr, wr_addr, wr_data;
  logic [16:0] in_data;
  logic [15:0] got_a[$], got_d[$], ev[$];
  logic [16:0] dq[$];
  int          checks = 0, fails = 0, done_cnt = 0;
  pe_output_writer dut (
    .clk(clk), .rst(rst), .start(start), .row_length(row_length), .out_rows(out_rows),
    .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
    end
    if (done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clr();
    got_a.delete();
    got_d.delete();
    done_cnt = 0;
  endtask
  task automatic do_start(input logic [9:0] rl, input logic [9:0] rows, input logic [15:0] base);
    @(posedge clk); #1;
    start = 1; row_length = rl; out_rows = rows; base_addr = base;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic feed(input logic [16:0] q[$], input bit gap, input int restart_at);
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1; in_data = q[i];
      if (i == restart_at) begin start = 1; base_addr = 16'h0200; end
      @(posedge clk); #1;
      start = 0;
      if (gap) begin
        in_valid = 0; in_data = 17'h1ABCD;
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 300) begin @(negedge clk); k++; end
    chk("done_seen", 32'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_after_done", busy, 0);
  endtask
  task automatic expect_writes(input logic [15:0] base, input logic [15:0] ed[$]);
    chk("n_writes", got_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
      chk($sformatf("addr[%0d]", i), got_a[i], base + 16'(i));
      chk($sformatf("data[%0d]", i), got_d[i], ed[i]);
    end
  endtask
  task automatic run_basic(input bit gap, input int restart_at);
    clr();
    do_start(6, 2, 16'h0100);
    dq.delete();
    for (int i = 0; i < 12; i++) dq.push_back(17'(i));
    feed(dq, gap, restart_at);
    wait_done();
    ev = {16'd0, 16'd1, 16'd2, 16'd3, 16'd6, 16'd7, 16'd8, 16'd9};
    expect_writes(16'h0100, ev);
    chk("basic_overflow", overflow, 0);
  endtask
  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = 0; wr_ready = 1;
    row_length = 0; out_rows = 0; base_addr = 0;
    #2;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    run_basic(0, -1);
    run_basic(1, -1);
    run_basic(0, 5);
    clr();
    do_start(3, 4, 16'h0400);
    dq = {17'h09000, 17'h0, 17'h0, 17'h10000, 17'h0, 17'h0, 17'h1FFFF, 17'h0, 17'h0, 17'h00123, 17'h0, 17'h0};
    feed(dq, 0, -1);
    wait_done();
    ev = {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0123};
    expect_writes(16'h0400, ev);
    clr();
    wr_ready = 0;
    do_start(12, 1, 16'h0300);
    dq.delete();
    for (int i = 0; i < 12; i++) dq.push_back(17'(i));
    feed(dq, 0, -1);
    @(negedge clk);
    chk("bp_overflow", overflow, 1);
    chk("bp_wr_valid", wr_valid, 1);
    chk("bp_head_addr", wr_addr, 16'h0300);
    chk("bp_head_data", wr_data, 0);
    repeat (3) @(negedge clk);
    chk("bp_stable_addr", wr_addr, 16'h0300);
    chk("bp_busy_drain", busy, 1);
    chk("bp_no_done", done_cnt, 0);
    @(posedge clk); #1;
    wr_ready = 1;
    wait_done();
    ev = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    expect_writes(16'h0300, ev);
    chk("bp_overflow_sticky", overflow, 1);
    clr();
    do_start(6, 2, 16'h0100);
    chk("start_clears_overflow", overflow, 0);
    dq = {17'd0, 17'd1, 17'd2, 17'd3, 17'd4};
    feed(dq, 0, -1);
    rst = 1; #1;
    chk("midrst_wr_valid", wr_valid, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    run_basic(0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
